execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Pipeline stage directly upstream of the memory-access stage.
- Applies the ALU operation to the decoded operands.
- Passes the write-back and memory-access control fields, store data and the destination register through its output pipeline register.
- Single-cycle ops complete on one edge. MUL is an iterative multi-cycle operation that stalls the upstream stage and inserts bubbles downstream.

Parameters:
- MUL_BITS, 1, multiplier bits retired per cycle; legal values 1, 2, 4. Multiply step count N = 32/MUL_BITS.

Ports:
- clk  in  1  stage clock; all registers update on the falling edge, matching the downstream stage.
- reset  in  1  asynchronous, active-high reset.
- validIn  in  1  input instruction is valid; 0 = bubble.
- writeBackControlIn  in  2  write-back control, passed through.
- memAccessControlIn  in  2  {memRead, memWrite}, passed through.
- aluOp  in  4  operation select.
- aluSrc  in  1  1 = second operand is immediate, 0 = operandB.
- operandA  in  32  first source value.
- operandB  in  32  second source value; also the store data.
- immediate  in  32  sign-extended immediate.
- rdIn  in  5  destination register.
- stall  out  1  combinational; upstream must hold all inputs while this is 1.
- writeBackControlOut  out  2  registered.
- memAccessControlOut  out  2  registered.
- resultOut  out  32  registered ALU result; used downstream as the memory address or write-back value.
- writeDataOut  out  32  registered copy of operandB.
- rdOut  out  5  registered.

Behaviour:
- Reset (async, active-high):
  - All outputs are 0.
  - State = IDLE, step counter = 0, multiplier registers = 0.
  - stall is driven only from state and inputs after reset.
- Operand selection: B = aluSrc ? immediate : operandB.
- aluOp encodings:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount = B[4:0].
  - 8 SLT (signed, result 1/0), 9 SLTU (unsigned, result 1/0).
  - 10 MUL (low 32 bits of A*B; the same result for signed or unsigned).
  - 11..15 give result 0.
- Arithmetic wraps modulo 2^32. No flags and no overflow trap.
- Bubble: when validIn=0 in IDLE, the next edge writes writeBackControlOut=0, memAccessControlOut=0, rdOut=0, resultOut=0, writeDataOut=0.
- Single-cycle op (validIn=1, aluOp!=10, IDLE):
  - The next falling edge registers the result and passes all fields through.
  - Latency is 1 edge. stall=0.
- State machine IDLE/BUSY for MUL:
  - IDLE, validIn=1, aluOp=10:
    - stall=1.
    - At the edge: latch A and B into the multiplicand and multiplier registers, clear the accumulator, counter=N, go to BUSY.
    - Outputs take bubble values.
  - BUSY:
    - Each edge: accumulator += multiplicand * multiplier[MUL_BITS-1:0]; multiplicand <<= MUL_BITS; multiplier >>= MUL_BITS; counter -= 1.
    - stall = (counter != 1).
    - While counter != 1, outputs take bubble values at each edge.
  - BUSY with counter==1:
    - stall=0.
    - At the edge: complete the final step and write the final accumulator to resultOut.
    - writeBackControlOut, memAccessControlOut, writeDataOut and rdOut take the held inputs, which are still the MUL instruction.
    - Go to IDLE. The upstream stage advances on this same edge.
  - Total: a MUL occupies N+1 edges; the downstream stage sees N bubbles, then the result.
- Inputs during BUSY: validIn, aluOp, aluSrc and the operands are ignored. The upstream stage guarantees they are held.
- MUL following MUL: re-enters BUSY from IDLE on the next edge with no extra gap.
- Reset mid-multiply:
  - Aborts the multiply; state goes to IDLE and the partial product is discarded.
  - stall immediately equals (validIn && aluOp==10).
- MUL with validIn=0 is a bubble and never enters BUSY.

Decomposition:
- Shared package holds:
  - aluOp encodings (ALU_ADD..ALU_MUL).
  - Control field widths (2 bits write-back, 2 bits memory access).
  - Data width 32 and register-index width 5.
  - memAccessControl bit positions (bit1 read, bit0 write), shared with the memory-access stage.
- One sub-module, iterative_multiplier:
  - start, busy, last and result signals; parameterised by MUL_BITS.
  - Contains the counter, shift registers and accumulator.
- The ALU mux and the pipeline register stay in execute_stage.

Test Plan:
- Reset asserted asynchronously between edges -> all outputs 0 immediately; stall=0 with validIn=0.
- ADD: A=5, B=7, aluSrc=0, rdIn=3, writeBackControlIn=2'b10 -> after 1 falling edge: resultOut=12, rdOut=3, writeBackControlOut=2'b10, writeDataOut=7.
- Store address: aluSrc=1, A=2, immediate=4, operandB=99, memAccessControlIn=2'b01 -> resultOut=6, writeDataOut=99, memAccessControlOut=2'b01.
- SRA and SLT:
  - SRA A=32'h80000000, B=4 -> resultOut=32'hF8000000.
  - SLT A=-1, B=1 -> 1.
  - SLTU A=-1, B=1 -> 0.
- MUL, MUL_BITS=1:
  - A=32'h0001_0003, B=32'h0000_0005, rdIn=9.
  - stall is high for 32 edges; 32 bubble outputs follow.
  - Next edge: resultOut=32'h0005_000F, rdOut=9, stall=0.
  - The following instruction, ADD 1+1, appears 1 edge later with result 2.
- Reset at the 10th BUSY edge of a MUL -> outputs 0 and state IDLE. With the MUL still presented afterwards, it restarts and completes with the correct product after N+1 edges.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage and its neighbours.
// Holds ALU opcodes, field widths and memory-control bit positions.
package execute_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int WB_W   = 2;
    localparam int MEM_W  = 2;

    // memAccessControl bit positions, shared with the memory-access stage
    localparam int MEM_READ_BIT  = 1;
    localparam int MEM_WRITE_BIT = 0;

    localparam int CNT_W = 6;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_MUL  = 4'd10
    } alu_op_t;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_t;

endpackage

// File: rtl/iterative_multiplier.sv
// Shift-add multiplier retiring MUL_BITS multiplier bits per edge.
// Ports: clk, reset, start, a, b in; busy, last, result (final sum) out.
module iterative_multiplier
    import execute_stage_pkg::*;
#(
    parameter int MUL_BITS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              last,
    output logic [DATA_W-1:0] result
);

    localparam int N = DATA_W / MUL_BITS;

    mul_state_t        state;
    mul_state_t        next_state;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] partial;

    assign partial = mcand * DATA_W'(mplier[MUL_BITS-1:0]);

    // result is the accumulator including the step taken on this edge,
    // so the caller can capture the product on the final BUSY edge.
    assign result = acc + partial;

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        last       = 1'b0;
        case (state)
            MUL_IDLE: begin
                if (start) next_state = MUL_BUSY;
            end
            MUL_BUSY: begin
                busy = 1'b1;
                last = (count == CNT_W'(1));
                if (last) next_state = MUL_IDLE;
            end
            default: next_state = MUL_IDLE;
        endcase
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state  <= MUL_IDLE;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else begin
            state <= next_state;
            if (state == MUL_IDLE && start) begin
                mcand  <= a;
                mplier <= b;
                acc    <= '0;
                count  <= CNT_W'(N);
            end else if (state == MUL_BUSY) begin
                acc    <= result;
                mcand  <= mcand << MUL_BITS;
                mplier <= mplier >> MUL_BITS;
                count  <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute pipeline stage: ALU, iterative MUL and output pipeline register.
// Ports: decoded operands/controls in; stall and registered results out.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int MUL_BITS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              validIn,
    input  logic [WB_W-1:0]   writeBackControlIn,
    input  logic [MEM_W-1:0]  memAccessControlIn,
    input  logic [3:0]        aluOp,
    input  logic              aluSrc,
    input  logic [DATA_W-1:0] operandA,
    input  logic [DATA_W-1:0] operandB,
    input  logic [DATA_W-1:0] immediate,
    input  logic [REG_W-1:0]  rdIn,
    output logic              stall,
    output logic [WB_W-1:0]   writeBackControlOut,
    output logic [MEM_W-1:0]  memAccessControlOut,
    output logic [DATA_W-1:0] resultOut,
    output logic [DATA_W-1:0] writeDataOut,
    output logic [REG_W-1:0]  rdOut
);

    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mul_result;
    logic              mul_req;
    logic              mul_start;
    logic              mul_busy;
    logic              mul_last;

    assign src_b     = aluSrc ? immediate : operandB;
    assign mul_req   = validIn && (aluOp == ALU_MUL);
    assign mul_start = mul_req && !mul_busy;

    // While busy the held inputs are ignored; only the step count matters.
    assign stall = mul_busy ? !mul_last : mul_req;

    iterative_multiplier #(
        .MUL_BITS(MUL_BITS)
    ) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (mul_start),
        .a     (operandA),
        .b     (src_b),
        .busy  (mul_busy),
        .last  (mul_last),
        .result(mul_result)
    );

    always_comb begin
        alu_result = '0;
        case (aluOp)
            ALU_ADD:  alu_result = operandA + src_b;
            ALU_SUB:  alu_result = operandA - src_b;
            ALU_AND:  alu_result = operandA & src_b;
            ALU_OR:   alu_result = operandA | src_b;
            ALU_XOR:  alu_result = operandA ^ src_b;
            ALU_SLL:  alu_result = operandA << src_b[4:0];
            ALU_SRL:  alu_result = operandA >> src_b[4:0];
            ALU_SRA:  alu_result = $signed(operandA) >>> src_b[4:0];
            ALU_SLT:  alu_result = DATA_W'($signed(operandA) < $signed(src_b));
            ALU_SLTU: alu_result = DATA_W'(operandA < src_b);
            default:  alu_result = '0;
        endcase
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            writeBackControlOut <= '0;
            memAccessControlOut <= '0;
            resultOut           <= '0;
            writeDataOut        <= '0;
            rdOut               <= '0;
        end else if (mul_last) begin
            // Upstream still holds the MUL instruction on this edge.
            writeBackControlOut <= writeBackControlIn;
            memAccessControlOut <= memAccessControlIn;
            resultOut           <= mul_result;
            writeDataOut        <= operandB;
            rdOut               <= rdIn;
        end else if (mul_busy || !validIn || aluOp == ALU_MUL) begin
            writeBackControlOut <= '0;
            memAccessControlOut <= '0;
            resultOut           <= '0;
            writeDataOut        <= '0;
            rdOut               <= '0;
        end else begin
            writeBackControlOut <= writeBackControlIn;
            memAccessControlOut <= memAccessControlIn;
            resultOut           <= alu_result;
            writeDataOut        <= operandB;
            rdOut               <= rdIn;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage (MUL_BITS=1).
// Vector table, MUL corner sequences and randomized model comparison.
module tb_execute_stage;
    import execute_stage_pkg::*;

    localparam int N = 32;

    logic        clk;
    logic        reset;
    logic        validIn;
    logic [1:0]  writeBackControlIn;
    logic [1:0]  memAccessControlIn;
    logic [3:0]  aluOp;
    logic        aluSrc;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic [31:0] immediate;
    logic [4:0]  rdIn;
    logic        stall;
    logic [1:0]  writeBackControlOut;
    logic [1:0]  memAccessControlOut;
    logic [31:0] resultOut;
    logic [31:0] writeDataOut;
    logic [4:0]  rdOut;

    int tests = 0;
    int fails = 0;

    execute_stage #(.MUL_BITS(1)) dut (
        .clk                (clk),
        .reset              (reset),
        .validIn            (validIn),
        .writeBackControlIn (writeBackControlIn),
        .memAccessControlIn (memAccessControlIn),
        .aluOp              (aluOp),
        .aluSrc             (aluSrc),
        .operandA           (operandA),
        .operandB           (operandB),
        .immediate          (immediate),
        .rdIn               (rdIn),
        .stall              (stall),
        .writeBackControlOut(writeBackControlOut),
        .memAccessControlOut(memAccessControlOut),
        .resultOut          (resultOut),
        .writeDataOut       (writeDataOut),
        .rdOut              (rdOut)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic        src;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [1:0]  wb;
        logic [1:0]  mem;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return 32'(sa / (longint'(1) << sh) -
                        ((sa < 0 && sa % (longint'(1) << sh) != 0) ? 1 : 0));
            4'd8:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            4'd10:   return 32'(longint'(a) * longint'(b));
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input vec_t v);
        validIn            = v.valid;
        aluOp              = v.op;
        aluSrc             = v.src;
        operandA           = v.a;
        operandB           = v.b;
        immediate          = v.imm;
        rdIn               = v.rd;
        writeBackControlIn = v.wb;
        memAccessControlIn = v.mem;
    endtask

    task automatic edge_step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_single(input vec_t v, input string name);
        drive(v);
        #1;
        chk({name, " stall"}, 32'(stall), 32'd0);
        edge_step();
        chk({name, " result"}, resultOut, v.valid ? v.exp : 32'd0);
        chk({name, " rd"}, 32'(rdOut), v.valid ? 32'(v.rd) : 32'd0);
        chk({name, " wb"}, 32'(writeBackControlOut),
            v.valid ? 32'(v.wb) : 32'd0);
        chk({name, " mem"}, 32'(memAccessControlOut),
            v.valid ? 32'(v.mem) : 32'd0);
        chk({name, " wdata"}, writeDataOut, v.valid ? v.b : 32'd0);
    endtask

    // Waits out a MUL already presented on the inputs, checking N
    // stalled edges of bubbles and then the product on edge N+1.
    task automatic finish_mul(input vec_t v, input string name);
        int  hi;
        bit  bub_ok;
        hi     = 0;
        bub_ok = 1;
        #1;
        while (stall && hi < 4 * N) begin
            edge_step();
            hi++;
            if (resultOut !== 0 || rdOut !== 0 || writeDataOut !== 0 ||
                writeBackControlOut !== 0 || memAccessControlOut !== 0)
                bub_ok = 0;
        end
        chk({name, " stall edges"}, 32'(hi), 32'(N));
        chk({name, " bubbles"}, 32'(bub_ok), 32'd1);
        edge_step();
        chk({name, " product"}, resultOut, v.exp);
        chk({name, " rd"}, 32'(rdOut), 32'(v.rd));
        chk({name, " wb"}, 32'(writeBackControlOut), 32'(v.wb));
        chk({name, " wdata"}, writeDataOut, v.b);
    endtask

    task automatic do_mul(input vec_t v, input string name);
        drive(v);
        #1;
        chk({name, " stall start"}, 32'(stall), 32'd1);
        finish_mul(v, name);
    endtask

    function automatic vec_t mk(input logic valid, input logic [3:0] op,
                                input logic src, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] imm,
                                input logic [4:0] rd, input logic [1:0] wb,
                                input logic [1:0] mem,
                                input logic [31:0] exp);
        vec_t v;
        v.valid = valid; v.op = op; v.src = src; v.a = a; v.b = b;
        v.imm = imm; v.rd = rd; v.wb = wb; v.mem = mem; v.exp = exp;
        return v;
    endfunction

    vec_t tbl[$];
    vec_t v;
    vec_t m;

    initial begin
        reset = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #12;
        chk("reset result", resultOut, 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        reset = 1'b0;

        tbl.push_back(mk(1, 0, 0, 5, 7, 0, 3, 2'b10, 0, 12));
        tbl.push_back(mk(1, 0, 1, 2, 99, 4, 1, 0, 2'b01, 6));
        tbl.push_back(mk(1, 7, 0, 32'h80000000, 4, 0, 4, 1, 0,
                         32'hF8000000));
        tbl.push_back(mk(1, 8, 0, 32'hFFFFFFFF, 1, 0, 5, 1, 0, 1));
        tbl.push_back(mk(1, 9, 0, 32'hFFFFFFFF, 1, 0, 6, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3, 5, 0, 7, 3, 2'b10, 32'hFFFFFFFE));
        tbl.push_back(mk(1, 2, 0, 32'hF0F0, 32'hFF00, 0, 8, 1, 0, 32'hF000));
        tbl.push_back(mk(1, 3, 1, 32'hF0, 1, 32'h0F, 9, 1, 0, 32'hFF));
        tbl.push_back(mk(1, 4, 0, 32'hFF, 32'h0F, 0, 10, 1, 0, 32'hF0));
        tbl.push_back(mk(1, 5, 0, 1, 32'h3F, 0, 11, 1, 0, 32'h80000000));
        tbl.push_back(mk(1, 6, 0, 32'h80000000, 31, 0, 12, 1, 0, 1));
        tbl.push_back(mk(1, 11, 0, 9, 9, 0, 13, 1, 0, 0));
        tbl.push_back(mk(1, 15, 0, 9, 9, 0, 14, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 5, 7, 0, 3, 2'b11, 2'b11, 12));
        tbl.push_back(mk(0, 10, 0, 5, 7, 0, 3, 2'b11, 2'b11, 35));

        foreach (tbl[i]) do_single(tbl[i], $sformatf("vec%0d", i));

        // asynchronous reset between edges after a live result
        do_single(mk(1, 0, 0, 5, 7, 0, 3, 2'b10, 0, 12), "pre-reset");
        validIn = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("async reset result", resultOut, 32'd0);
        chk("async reset rd", 32'(rdOut), 32'd0);
        chk("async reset wdata", writeDataOut, 32'd0);
        chk("async reset stall", 32'(stall), 32'd0);
        #1 reset = 1'b0;

        m = mk(1, 10, 0, 32'h00010003, 5, 0, 9, 2'b01, 0, 32'h0005000F);
        do_mul(m, "mul");
        do_single(mk(1, 0, 0, 1, 1, 0, 2, 1, 0, 2), "add after mul");

        do_mul(mk(1, 10, 0, 7, 6, 0, 1, 1, 0, 42), "mul back1");
        do_mul(mk(1, 10, 1, 32'hFFFFFFFF, 0, 3, 2, 1, 0, 32'hFFFFFFFD),
               "mul back2");

        // reset at the 10th BUSY edge; MUL stays presented and restarts
        m = mk(1, 10, 0, 32'h12345678, 32'h9ABCDEF1, 0, 17, 2, 1,
               model(10, 32'h12345678, 32'h9ABCDEF1));
        drive(m);
        for (int i = 0; i < 10; i++) edge_step();
        reset = 1'b1;
        #1;
        chk("mid reset result", resultOut, 32'd0);
        chk("mid reset stall", 32'(stall), 32'd1);
        #1 reset = 1'b0;
        finish_mul(m, "mul restart");

        for (int i = 0; i < 60; i++) begin
            v.valid = ($urandom_range(0, 7) != 0);
            v.op    = 4'($urandom_range(0, 15));
            v.src   = 1'($urandom_range(0, 1));
            v.a     = $urandom;
            v.b     = $urandom;
            v.imm   = $urandom;
            v.rd    = 5'($urandom);
            v.wb    = 2'($urandom);
            v.mem   = 2'($urandom);
            v.exp   = model(v.op, v.a, v.src ? v.imm : v.b);
            if (v.valid && v.op == 4'd10)
                do_mul(v, $sformatf("rnd%0d mul", i));
            else
                do_single(v, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
